// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conv-layer read scheduler: FSM state encoding
// and the bit layout of packed shape words (w, h, n_wrap_c).
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        RUN   = 3'd2,
        GAP   = 3'd3,
        DRAIN = 3'd4
    } sched_state_t;

    localparam int W_LSB  = 0;
    localparam int H_LSB  = 9;
    localparam int C_LSB  = 18;
    localparam int W_BITS = 9;
    localparam int H_BITS = 9;
    localparam int C_BITS = 7;

    // Assemble a packed shape word from its three fields.
    function automatic logic [W_BITS+H_BITS+C_BITS-1:0] pack_shape(
        input logic [C_BITS-1:0] c,
        input logic [H_BITS-1:0] h,
        input logic [W_BITS-1:0] w
    );
        logic [W_BITS+H_BITS+C_BITS-1:0] s;
        s = {(W_BITS+H_BITS+C_BITS){1'b0}};
        s[W_LSB +: W_BITS] = w;
        s[H_LSB +: H_BITS] = h;
        s[C_LSB +: C_BITS] = c;
        return s;
    endfunction

endpackage

// File: rtl/sched_credit_counter.sv
// Saturating credit counter for feature-map buffer words: one add and one subtract
// per cycle folded into a single update, clamped to [0, 2^B_ADDR] with a sticky error flag.
module sched_credit_counter
    import conv_sched_pkg::*;
#(
    parameter int B_ADDR = 9
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            add_en,
    input  logic [B_ADDR:0] add_val,
    input  logic            sub_en,
    input  logic [B_ADDR:0] sub_val,
    output logic [B_ADDR:0] avail,
    output logic [B_ADDR:0] free_words,
    output logic            err_ovf
);

    localparam logic [B_ADDR+2:0] CAP_W = {2'b00, 1'b1, {B_ADDR{1'b0}}};
    localparam logic [B_ADDR:0]   CAP_N = {1'b1, {B_ADDR{1'b0}}};

    logic [B_ADDR+2:0] add_term_s;
    logic [B_ADDR+2:0] sub_term_s;
    logic [B_ADDR+2:0] sum_s;
    logic [B_ADDR:0]   next_s;
    logic              ovf_s;
    logic [B_ADDR:0]   avail_r;
    logic [B_ADDR:0]   free_r;
    logic              ovf_r;

    // Next credit value; the extra top bits act as sign so underflow is detectable
    always_comb begin
        add_term_s = add_en ? {2'b00, add_val} : {(B_ADDR+3){1'b0}};
        sub_term_s = sub_en ? {2'b00, sub_val} : {(B_ADDR+3){1'b0}};
        sum_s      = {2'b00, avail_r} + add_term_s - sub_term_s;
        if (sum_s[B_ADDR+2]) begin
            next_s = {(B_ADDR+1){1'b0}};
            ovf_s  = 1'b1;
        end else if (sum_s > CAP_W) begin
            next_s = CAP_N;
            ovf_s  = 1'b1;
        end else begin
            next_s = sum_s[B_ADDR:0];
            ovf_s  = 1'b0;
        end
    end

    // Credit, free-space and sticky error registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            avail_r <= {(B_ADDR+1){1'b0}};
            free_r  <= CAP_N;
            ovf_r   <= 1'b0;
        end else begin
            avail_r <= next_s;
            free_r  <= CAP_N - next_s;
            ovf_r   <= ovf_r | ovf_s;
        end
    end

    assign avail      = avail_r;
    assign free_words = free_r;
    assign err_ovf    = ovf_r;

endmodule

// File: rtl/conv_read_scheduler.sv
// Per-layer sequencer for the strided buffer reader: accepts a layer command, waits for
// buffer credit, sweeps the ftm n_pass times, drains the read pipe and releases credit.
module conv_read_scheduler
    import conv_sched_pkg::*;
#(
    parameter int B_BUF_ADDR = 9,
    parameter int B_SHAPE    = 25,
    parameter int B_PASS     = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_stride,
    input  logic [1:0]            cmd_pad,
    input  logic [B_SHAPE-1:0]    cmd_wei_shape,
    input  logic [B_SHAPE-1:0]    cmd_ftm_shape,
    input  logic [B_BUF_ADDR:0]   cmd_ftm_words,
    input  logic [B_PASS-1:0]     cmd_n_pass,
    input  logic                  wr_commit,
    input  logic [B_BUF_ADDR:0]   wr_words,
    output logic [B_BUF_ADDR:0]   free_words,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [1:0]            stride,
    output logic [1:0]            pad,
    output logic [B_SHAPE-1:0]    wei_shape,
    output logic [B_SHAPE-1:0]    ftm_shape,
    output logic                  rptr_incr_en,
    input  logic                  is_last,
    output logic                  out_valid,
    output logic                  out_pass_last,
    output logic                  out_layer_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf
);

    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);
    localparam logic [B_PASS-1:0] PASS_ONE   = {{(B_PASS-1){1'b0}}, 1'b1};
    localparam logic [B_PASS-1:0] PASS_ZERO  = {B_PASS{1'b0}};

    sched_state_t           state_r;
    logic [1:0]             cfg_stride_r;
    logic [1:0]             cfg_pad_r;
    logic [B_SHAPE-1:0]     cfg_wei_r;
    logic [B_SHAPE-1:0]     cfg_ftm_r;
    logic [B_BUF_ADDR:0]    cfg_words_r;
    logic [B_PASS-1:0]      last_pass_r;
    logic [B_PASS-1:0]      pass_cnt_r;
    logic [2:0]             drain_cnt_r;
    logic                   rd_en_r;
    logic                   rptr_r;
    logic                   cmd_ready_r;
    logic                   busy_r;
    logic                   done_r;
    logic [RD_LAT-1:0]      vld_pipe_r;
    logic [RD_LAT-1:0]      pl_pipe_r;
    logic [RD_LAT-1:0]      ll_pipe_r;

    logic                   hit_s;
    logic                   final_pass_s;
    logic                   release_s;
    logic [B_BUF_ADDR:0]    avail_s;

    assign hit_s        = (state_r == RUN) && rd_en_r && is_last;
    assign final_pass_s = (pass_cnt_r == last_pass_r);
    assign release_s    = (state_r == DRAIN) && (drain_cnt_r == DRAIN_LAST) && !abort;

    sched_credit_counter #(
        .B_ADDR     (B_BUF_ADDR)
    ) u_credit (
        .clk        (clk),
        .rstn       (rstn),
        .add_en     (wr_commit),
        .add_val    (wr_words),
        .sub_en     (release_s),
        .sub_val    (cfg_words_r),
        .avail      (avail_s),
        .free_words (free_words),
        .err_ovf    (err_ovf)
    );

    // Layer sequencing FSM; abort overrides every transition and returns to IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            cfg_stride_r <= 2'b00;
            cfg_pad_r    <= 2'b00;
            cfg_wei_r    <= {B_SHAPE{1'b0}};
            cfg_ftm_r    <= {B_SHAPE{1'b0}};
            cfg_words_r  <= {(B_BUF_ADDR+1){1'b0}};
            last_pass_r  <= PASS_ZERO;
            pass_cnt_r   <= PASS_ZERO;
            drain_cnt_r  <= 3'd0;
            rd_en_r      <= 1'b0;
            rptr_r       <= 1'b0;
            cmd_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (abort) begin
            state_r      <= IDLE;
            pass_cnt_r   <= PASS_ZERO;
            drain_cnt_r  <= 3'd0;
            rd_en_r      <= 1'b0;
            rptr_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cmd_ready_r <= 1'b1;
                    if (cmd_valid && cmd_ready_r) begin
                        cfg_stride_r <= cmd_stride;
                        cfg_pad_r    <= cmd_pad;
                        cfg_wei_r    <= cmd_wei_shape;
                        cfg_ftm_r    <= cmd_ftm_shape;
                        cfg_words_r  <= cmd_ftm_words;
                        last_pass_r  <= (cmd_n_pass == PASS_ZERO) ? PASS_ZERO
                                                                  : cmd_n_pass - PASS_ONE;
                        pass_cnt_r   <= PASS_ZERO;
                        cmd_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= WAIT;
                    end
                end
                WAIT: begin
                    if (avail_s >= cfg_words_r) begin
                        state_r <= RUN;
                        rd_en_r <= 1'b1;
                        rptr_r  <= (last_pass_r == PASS_ZERO);
                    end
                end
                RUN: begin
                    // rd_en stays high for the whole sweep; the reader restarts x/y when it drops
                    if (is_last) begin
                        rd_en_r <= 1'b0;
                        rptr_r  <= 1'b0;
                        if (final_pass_s) begin
                            drain_cnt_r <= 3'd0;
                            state_r     <= DRAIN;
                        end else begin
                            pass_cnt_r <= pass_cnt_r + PASS_ONE;
                            state_r    <= GAP;
                        end
                    end
                end
                GAP: begin
                    state_r <= RUN;
                    rd_en_r <= 1'b1;
                    rptr_r  <= final_pass_s;
                end
                DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r     <= IDLE;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rd_en_r     <= 1'b0;
                    rptr_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency delay pipes aligning valid and last flags with data at the datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_r <= {RD_LAT{1'b0}};
            pl_pipe_r  <= {RD_LAT{1'b0}};
            ll_pipe_r  <= {RD_LAT{1'b0}};
        end else if (abort) begin
            vld_pipe_r <= {RD_LAT{1'b0}};
            pl_pipe_r  <= {RD_LAT{1'b0}};
            ll_pipe_r  <= {RD_LAT{1'b0}};
        end else begin
            vld_pipe_r[0] <= rd_en_r;
            pl_pipe_r[0]  <= hit_s;
            ll_pipe_r[0]  <= hit_s && final_pass_s;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                pl_pipe_r[i]  <= pl_pipe_r[i-1];
                ll_pipe_r[i]  <= ll_pipe_r[i-1];
            end
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign stride         = cfg_stride_r;
    assign pad            = cfg_pad_r;
    assign wei_shape      = cfg_wei_r;
    assign ftm_shape      = cfg_ftm_r;
    assign rd_en          = rd_en_r;
    assign rptr_incr_en   = rptr_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign out_valid      = vld_pipe_r[RD_LAT-1];
    assign out_pass_last  = pl_pipe_r[RD_LAT-1];
    assign out_layer_last = ll_pipe_r[RD_LAT-1];

endmodule

// File: tb/tb_conv_read_scheduler.sv
// Scoreboard bench for conv_read_scheduler: a reader model answers rd_en with is_last,
// the driver queues expected words/done credits, and a negedge monitor checks them.
module tb_conv_read_scheduler;

    localparam int B_BUF_ADDR = 9;
    localparam int B_SHAPE    = 25;
    localparam int B_PASS     = 8;
    localparam int RD_LAT     = 2;
    localparam int KW = 3, KH = 3, FW = 5, FH = 5, STR = 1, PD = 0;
    localparam int SWEEP = ((FW + 2*PD - KW)/STR + 1) * ((FH + 2*PD - KH)/STR + 1) * KW * KH;

    typedef struct packed {
        logic pass_last;
        logic layer_last;
    } word_t;

    logic                  clk, rstn;
    logic                  cmd_valid, cmd_ready;
    logic [1:0]            cmd_stride, cmd_pad;
    logic [B_SHAPE-1:0]    cmd_wei_shape, cmd_ftm_shape;
    logic [B_BUF_ADDR:0]   cmd_ftm_words;
    logic [B_PASS-1:0]     cmd_n_pass;
    logic                  wr_commit;
    logic [B_BUF_ADDR:0]   wr_words;
    logic [B_BUF_ADDR:0]   free_words;
    logic                  abort;
    logic                  rd_en;
    logic [1:0]            stride, pad;
    logic [B_SHAPE-1:0]    wei_shape, ftm_shape;
    logic                  rptr_incr_en, is_last;
    logic                  out_valid, out_pass_last, out_layer_last;
    logic                  busy, done, err_ovf;

    int total = 0;
    int bad   = 0;

    word_t exp_q[$];
    int    done_q[$];
    int    islast_q[$];
    int    runs[$];
    int    gaps[$];
    int    cyc = 0, run_len = 0, fall_cyc = 0, rd_total = 0, incr_total = 0, npl = 0, nll = 0;
    logic  has_fall = 1'b0, prev_rd = 1'b0;
    word_t mon_w;
    int    rd_cnt;

    conv_read_scheduler #(
        .B_BUF_ADDR (B_BUF_ADDR), .B_SHAPE (B_SHAPE), .B_PASS (B_PASS), .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk), .rstn (rstn),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_stride (cmd_stride), .cmd_pad (cmd_pad),
        .cmd_wei_shape (cmd_wei_shape), .cmd_ftm_shape (cmd_ftm_shape),
        .cmd_ftm_words (cmd_ftm_words), .cmd_n_pass (cmd_n_pass),
        .wr_commit (wr_commit), .wr_words (wr_words), .free_words (free_words),
        .abort (abort), .rd_en (rd_en), .stride (stride), .pad (pad),
        .wei_shape (wei_shape), .ftm_shape (ftm_shape),
        .rptr_incr_en (rptr_incr_en), .is_last (is_last),
        .out_valid (out_valid), .out_pass_last (out_pass_last),
        .out_layer_last (out_layer_last), .busy (busy), .done (done), .err_ovf (err_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    // Reader model: counts consecutive rd_en cycles and flags the final read of a sweep
    always @(posedge clk or negedge rstn) begin
        if (!rstn)                    rd_cnt <= 0;
        else if (!rd_en)              rd_cnt <= 0;
        else if (rd_cnt == SWEEP - 1) rd_cnt <= 0;
        else                          rd_cnt <= rd_cnt + 1;
    end
    assign is_last = rd_en && (rd_cnt == SWEEP - 1);

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops expected words and done credits, and records rd_en run/gap structure
    always @(negedge clk) begin
        if (rstn) begin
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("out_pass_last", out_pass_last, mon_w.pass_last);
                    check("out_layer_last", out_layer_last, mon_w.layer_last);
                end
            end else if (out_pass_last || out_layer_last) begin
                check("last_flag_without_valid", 1, 0);
            end
            if (out_pass_last) begin
                npl++;
                if (islast_q.size() == 0) check("pass_last_without_is_last", 1, 0);
                else check("pass_last_latency", cyc - islast_q.pop_front(), RD_LAT);
            end
            if (out_layer_last) nll++;
            if (rd_en && is_last) islast_q.push_back(cyc);
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_free_words", free_words, done_q.pop_front());
            end
            if (rd_en) begin
                rd_total++;
                if (rptr_incr_en) incr_total++;
                if (!prev_rd && has_fall) gaps.push_back(cyc - fall_cyc);
                run_len++;
            end else if (prev_rd) begin
                runs.push_back(run_len);
                run_len  = 0;
                fall_cyc = cyc;
                has_fall = 1'b1;
            end
            prev_rd = rd_en;
        end else begin
            prev_rd = 1'b0;
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input int n);
        wr_commit = 1'b1;
        wr_words  = (B_BUF_ADDR+1)'(n);
        tick();
        wr_commit = 1'b0;
        wr_words  = '0;
    endtask

    task automatic reset_stats();
        runs.delete();
        gaps.delete();
        rd_total = 0; incr_total = 0; npl = 0; nll = 0; run_len = 0;
        has_fall = 1'b0;
    endtask

    task automatic push_layer(input int npass, input int free_after);
        word_t w;
        for (int p = 0; p < npass; p++) begin
            for (int i = 0; i < SWEEP; i++) begin
                w.pass_last  = (i == SWEEP - 1);
                w.layer_last = (i == SWEEP - 1) && (p == npass - 1);
                exp_q.push_back(w);
            end
        end
        done_q.push_back(free_after);
    endtask

    task automatic send_cmd(input int words, input int npass);
        int t;
        cmd_stride    = 2'(STR);
        cmd_pad       = 2'(PD);
        cmd_wei_shape = {7'd1, 9'd3, 9'd3};
        cmd_ftm_shape = {7'd1, 9'd5, 9'd5};
        cmd_ftm_words = (B_BUF_ADDR+1)'(words);
        cmd_n_pass    = B_PASS'(npass);
        cmd_valid     = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            tick();
            t++;
        end
        check("cmd_ready_seen", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("cfg_ftm_shape", ftm_shape, {7'd1, 9'd5, 9'd5});
        check("cfg_wei_shape", wei_shape, {7'd1, 9'd3, 9'd3});
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 2000) begin
            tick();
            t++;
        end
        check({name, "_done_seen"}, done, 1);
        tick();
        check({name, "_idle_after_done"}, busy, 0);
    endtask

    task automatic wait_rd_en();
        int t;
        t = 0;
        while (!rd_en && t < 200) begin
            tick();
            t++;
        end
        check("rd_en_started", rd_en, 1);
    endtask

    task automatic check_layer(input string name, input int npass);
        check({name, "_runs"}, runs.size(), npass);
        foreach (runs[i]) check({name, "_run_len"}, runs[i], SWEEP);
        check({name, "_gaps"}, gaps.size(), npass - 1);
        foreach (gaps[i]) check({name, "_gap_len"}, gaps[i], 1);
        check({name, "_rd_total"}, rd_total, SWEEP * npass);
        check({name, "_incr_cycles"}, incr_total, SWEEP);
        check({name, "_pass_last_count"}, npl, npass);
        check({name, "_layer_last_count"}, nll, 1);
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_stride = '0; cmd_pad = '0;
        cmd_wei_shape = '0; cmd_ftm_shape = '0; cmd_ftm_words = '0; cmd_n_pass = '0;
        wr_commit = 1'b0; wr_words = '0; abort = 1'b0;

        @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_free_words", free_words, 512);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err_ovf", err_ovf, 0);
        rstn = 1'b1;
        tick();
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        // single pass
        commit(25);
        check("credit_free_after_commit", free_words, 487);
        reset_stats();
        push_layer(1, 512);
        send_cmd(25, 1);
        wait_done("single");
        check_layer("single", 1);
        check("single_free_words", free_words, 512);

        // two passes
        commit(25);
        reset_stats();
        push_layer(2, 512);
        send_cmd(25, 2);
        wait_done("multi");
        check_layer("multi", 2);

        // credit wait: 20 of 25 words present
        commit(20);
        reset_stats();
        push_layer(1, 512);
        send_cmd(25, 1);
        repeat (5) tick();
        check("wait_rd_en_low", rd_en, 0);
        check("wait_busy", busy, 1);
        commit(5);
        tick();
        check("wait_rd_en_rise", rd_en, 1);
        wait_done("credit");
        check_layer("credit", 1);

        // commit coincident with the release cycle
        commit(25);
        reset_stats();
        push_layer(1, 502);
        send_cmd(25, 1);
        begin
            int t;
            t = 0;
            while (!out_layer_last && t < 500) begin
                tick();
                t++;
            end
            check("release_cycle_seen", out_layer_last, 1);
        end
        commit(10);
        check("simul_done", done, 1);
        check("simul_free_words", free_words, 502);
        wait_done("simul");

        // abort at read 40 with 25 words available
        commit(15);
        reset_stats();
        for (int i = 0; i < 38; i++) exp_q.push_back(word_t'(2'b00));
        send_cmd(25, 1);
        wait_rd_en();
        repeat (39) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rd_en", rd_en, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_free_words", free_words, 487);
        repeat (4) tick();
        check("abort_words_delivered", exp_q.size(), 0);
        check("abort_done_quiet", done_q.size(), 0);

        // abort in IDLE blocks a coincident command
        abort = 1'b1;
        cmd_valid = 1'b1;
        tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        tick();
        check("idle_abort_busy", busy, 0);

        // new command after abort uses the retained 25 words
        reset_stats();
        push_layer(1, 512);
        send_cmd(25, 1);
        wait_done("post_abort");
        check_layer("post_abort", 1);

        // n_pass of zero behaves as one pass
        commit(25);
        reset_stats();
        push_layer(1, 512);
        send_cmd(25, 0);
        wait_done("npass0");
        check_layer("npass0", 1);

        // zero-word ftm starts without credit
        reset_stats();
        push_layer(1, 512);
        send_cmd(0, 1);
        wait_done("words0");
        check_layer("words0", 1);

        // overflow saturation
        commit(300);
        check("ovf_first_free", free_words, 212);
        check("ovf_first_flag", err_ovf, 0);
        commit(300);
        check("ovf_sat_free", free_words, 0);
        check("ovf_flag", err_ovf, 1);

        // asynchronous reset mid-RUN
        reset_stats();
        for (int i = 0; i < 8; i++) exp_q.push_back(word_t'(2'b00));
        send_cmd(25, 1);
        wait_rd_en();
        repeat (10) tick();
        #1 rstn = 1'b0;
        #1;
        check("arst_rd_en", rd_en, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        check("arst_rptr", rptr_incr_en, 0);
        check("arst_err_ovf", err_ovf, 0);
        check("arst_ftm_shape", ftm_shape, 0);
        check("arst_free_words", free_words, 512);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        check("post_rst_free", free_words, 512);
        check("final_exp_empty", exp_q.size(), 0);
        check("final_done_empty", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_read_scheduler.md
Name: conv_read_scheduler

Overview:
- Sequences `strided_buffer_reader` for one conv layer command at a time.
- Accepts layer descriptors over a valid/ready port and waits until the feature-map buffer holds the whole ftm.
- Drives the reader for N output-channel passes, then releases buffer credit back to the ftm loader.
- Sits between the layer command queue, the ftm loader and the conv-unit datapath.

Parameters:
- `B_BUF_ADDR`, 9, buffer bank address width.
- `B_SHAPE`, 25, packed shape width: w[8:0], h[17:9], n_wrap_c[24:18].
- `B_PASS`, 8, pass-count width.
- `RD_LAT`, 2, reader-to-buffer read latency in cycles, 1..7.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  layer command valid.
- `cmd_ready`  out  1  scheduler accepts command.
- `cmd_stride`  in  2  conv stride.
- `cmd_pad`  in  2  padding.
- `cmd_wei_shape`  in  B_SHAPE  weight shape.
- `cmd_ftm_shape`  in  B_SHAPE  ftm shape.
- `cmd_ftm_words`  in  B_BUF_ADDR+1  per-bank words the ftm occupies.
- `cmd_n_pass`  in  B_PASS  sweeps of the ftm; 0 is treated as 1.
- `wr_commit`  in  1  loader committed words.
- `wr_words`  in  B_BUF_ADDR+1  word count for `wr_commit`.
- `free_words`  out  B_BUF_ADDR+1  2^B_BUF_ADDR minus `avail`.
- `abort`  in  1  synchronous abort.
- `rd_en`  out  1  to reader.
- `stride`  out  2  to reader.
- `pad`  out  2  to reader.
- `wei_shape`  out  B_SHAPE  to reader.
- `ftm_shape`  out  B_SHAPE  to reader.
- `rptr_incr_en`  out  1  to reader.
- `is_last`  in  1  from reader.
- `out_valid`  out  1  read data valid at datapath.
- `out_pass_last`  out  1  last word of a pass.
- `out_layer_last`  out  1  last word of the layer.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at layer end.
- `err_ovf`  out  1  sticky credit overflow.

Behaviour:
- Reset values: all outputs 0; `free_words`=2^B_BUF_ADDR; state IDLE; `avail`=0; delay pipes cleared.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all cmd fields into the config registers and go to WAIT.
  - Config outputs (`stride`, `pad`, `wei_shape`, `ftm_shape`) are driven from the config registers and are stable from acceptance until the return to IDLE.
- WAIT:
  - Go to RUN when `avail` >= `cfg_ftm_words`.
  - `cfg_ftm_words`=0 passes immediately.
  - The check uses the registered `avail`.
- RUN:
  - `rd_en`=1 continuously; it is never dropped mid-sweep, because the reader resets x/y on `rd_en`=0.
  - `rptr_incr_en`=1 only while `pass_cnt` == n_pass-1.
  - On `rd_en`&&`is_last`:
    - if not the final pass: increment `pass_cnt` and go to GAP;
    - otherwise go to DRAIN.
- GAP: one cycle with `rd_en`=0, then RUN.
- DRAIN:
  - Wait RD_LAT cycles for the delay pipe to empty.
  - Then pulse `done`, subtract `cfg_ftm_words` from `avail`, and go to IDLE.
  - The next command may be accepted no earlier than the following cycle.
- Output timing:
  - `out_valid` = `rd_en` delayed by exactly RD_LAT cycles through a shift register.
  - `out_pass_last` = (`rd_en`&&`is_last`) delayed by RD_LAT.
  - `out_layer_last` = `out_pass_last` on the final pass, coincident with the final `out_valid`.
- Credit counter `avail` (B_BUF_ADDR+1 bits):
  - +`wr_words` on `wr_commit`, in every state.
  - On the release cycle, a simultaneous `wr_commit` yields `avail` + `wr_words` - `cfg_ftm_words` in a single update.
  - If a result exceeds 2^B_BUF_ADDR: saturate at 2^B_BUF_ADDR and set `err_ovf`, which is cleared only by reset.
  - An underflow request clamps at 0 and also sets `err_ovf`.
- `abort`:
  - From any state, go to IDLE next cycle: `rd_en`=0, delay pipes cleared, no `done`, no credit release.
  - `abort` has priority over every other transition.
  - `abort` while in IDLE is a no-op; a coincident `cmd_valid` is not accepted.
- Reset mid-operation (`rstn` low) clears everything asynchronously, including `avail`.

Decomposition:
- Package `conv_sched_pkg` holds:
  - state enum IDLE/WAIT/RUN/GAP/DRAIN;
  - shape field offsets W_LSB=0, H_LSB=9, C_LSB=18;
  - field widths 9/9/7.
- Sub-module `sched_credit_counter`: saturating add/sub counter with overflow flag, instanced once for `avail`.

Test Plan:
- Single pass:
  - Stimulus: wei_shape={7'd1,9'd3,9'd3}, ftm_shape={7'd1,9'd5,9'd5}, stride=1, pad=0, ftm_words=25, n_pass=1; `wr_commit` of 25 before the command.
  - Required response: exactly 81 consecutive `rd_en` cycles; `rptr_incr_en`=1 throughout; `out_layer_last` RD_LAT cycles after the `is_last` cycle; `done` after the drain; `free_words` returns to 512.
- Multi-pass:
  - Stimulus: same layer with n_pass=2.
  - Required response: 81 `rd_en` cycles, 1 GAP cycle, 81 `rd_en` cycles; `rptr_incr_en` only during the second pass; 2 `out_pass_last` pulses; 1 `out_layer_last`.
- Credit wait:
  - Stimulus: command with ftm_words=25 while `avail`=20.
  - Required response: stays in WAIT with `rd_en`=0; after `wr_commit` of 5, `rd_en` rises the next cycle.
- Simultaneous commit and release:
  - Stimulus: `avail`=25, `wr_commit` of 10 on the release cycle of a 25-word layer.
  - Required response: `avail`=10, `free_words`=502.
- Abort mid-RUN:
  - Stimulus: assert `abort` at read 40.
  - Required response: `rd_en`=0 and `out_valid` cleared next cycle; no `done`; `avail` unchanged at 25; a new command is accepted afterwards.
- Overflow and async reset:
  - Stimulus: `wr_commit` 300 twice, then `rstn` low mid-RUN.
  - Required response: after the second commit `avail`=512 and `err_ovf`=1; on `rstn` low all outputs are 0 immediately with no clock edge.
